// File: rtl/acc_ctrl.sv
// Accumulator sequencer: accepts one command at a time, drives registered hs/ls
// load/shift/clear controls for N steps, then pulses done.
// Optional feature: define ACC_CTRL_CARRY_STOP_EN to end SHL early on carry_out.
module acc_ctrl (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [2:0] cmd_cnt,
    input  logic       abort,
    input  logic       carry_out,
    output logic [1:0] hs,
    output logic [1:0] ls,
    output logic       ah_inen,
    output logic       ah_reset,
    output logic       clr,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef struct packed {
        logic [1:0] hs;
        logic [1:0] ls;
        logic       ah_inen;
        logic       ah_reset;
        logic       clr;
    } ctl_t;

    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;

    function automatic ctl_t decode(input logic [2:0] op);
        ctl_t c;
        c = '0;
        case (op)
            3'b001: c.ls = 2'b11;
            3'b010: begin c.hs = 2'b11; c.ah_inen = 1'b1; end
            3'b011: begin c.hs = 2'b11; c.ls = 2'b11; c.ah_inen = 1'b1; end
            OP_SHL: begin c.hs = 2'b10; c.ls = 2'b10; end
            OP_SHR: begin c.hs = 2'b01; c.ls = 2'b01; end
            3'b110: c.ah_reset = 1'b1;
            3'b111: c.clr = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    ctl_t       ctl_q, ctl_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       aborted_q, aborted_d;
    logic       carry_stop;

`ifdef ACC_CTRL_CARRY_STOP_EN
    assign carry_stop = carry_out && (op_q == OP_SHL);
`else
    logic unused_carry;
    assign unused_carry = carry_out;
    assign carry_stop   = 1'b0;
`endif

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        ctl_d     = '0;
        ready_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            IDLE: begin
                // ready_q is low for the first cycle after reset, so nothing is accepted then.
                if (cmd_valid && ready_q) begin
                    state_d = EXEC;
                    op_d    = cmd_op;
                    if (cmd_op == OP_SHL || cmd_op == OP_SHR)
                        cnt_d = (cmd_cnt == 3'd0) ? 4'd8 : {1'b0, cmd_cnt};
                    else
                        cnt_d = 4'd1;
                    ctl_d  = decode(cmd_op);
                    busy_d = 1'b1;
                end else begin
                    ready_d = 1'b1;
                end
            end
            EXEC: begin
                busy_d = 1'b1;
                if (abort || carry_stop || cnt_q <= 4'd1) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    aborted_d = abort || carry_stop;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    ctl_d = decode(op_q);
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            op_q      <= 3'd0;
            cnt_q     <= 4'd0;
            ctl_q     <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            ctl_q     <= ctl_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign cmd_ready = ready_q;
    assign hs        = ctl_q.hs;
    assign ls        = ctl_q.ls;
    assign ah_inen   = ctl_q.ah_inen;
    assign ah_reset  = ctl_q.ah_reset;
    assign clr       = ctl_q.clr;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule
